// File: rtl/scan_scheduler.sv
// Channel-hopping scan scheduler: guards, listens and receives on each hop-table
// entry in turn, and hands captured packet events to a single-entry output buffer.
module scan_scheduler #(
  parameter int GUARD_CYCLES = 8,
  parameter int RX_TIMEOUT   = 376
) (
  input  logic        symbol_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [17:0] ch_list,
  input  logic [1:0]  ch_count,
  input  logic [15:0] dwell,
  output logic        sniff_en,
  output logic [5:0]  sniff_channel,
  input  logic        acc_addr_matched,
  input  logic        packet_detected,
  input  logic [8:0]  packet_len,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [5:0]  evt_channel,
  output logic [8:0]  evt_len,
  output logic        busy,
  output logic        overflow
);

  // state   | meaning
  // IDLE    | not scanning, sniffer disabled
  // GUARD   | sniffer disabled between dwells
  // LISTEN  | sniffer enabled, dwell timer running
  // RECEIVE | access address matched, waiting for packet or timeout

  localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam int RW = (RX_TIMEOUT < 2) ? 1 : $clog2(RX_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GUARD, LISTEN, RECEIVE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     idx, idx_nxt, idx_adv, eff_count;
  logic [GW-1:0]  guard_cnt, guard_nxt;
  logic [15:0]    dwell_cnt, dwell_nxt, dwell_load;
  logic [RW-1:0]  rx_cnt, rx_nxt;
  logic           cap;

  always_comb begin
    case (idx)
      2'd1:    sniff_channel = ch_list[11:6];
      2'd2:    sniff_channel = ch_list[17:12];
      default: sniff_channel = ch_list[5:0];
    endcase
  end

  assign eff_count  = (ch_count == 2'd0) ? 2'd1 : ch_count;
  assign idx_adv    = (idx >= eff_count - 2'd1) ? 2'd0 : idx + 2'd1;
  assign dwell_load = (dwell == 16'd0) ? 16'd1 : dwell;
  assign sniff_en   = (state == LISTEN) || (state == RECEIVE);
  assign busy       = (state != IDLE);

  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      guard_cnt <= '0;
      dwell_cnt <= '0;
      rx_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      guard_cnt <= guard_nxt;
      dwell_cnt <= dwell_nxt;
      rx_cnt    <= rx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    guard_nxt = guard_cnt;
    dwell_nxt = dwell_cnt;
    rx_nxt    = rx_cnt;
    cap       = 1'b0;
    if (stop && state != IDLE) begin
      state_nxt = IDLE;
      idx_nxt   = 2'd0;
      guard_nxt = '0;
      dwell_nxt = '0;
      rx_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = GUARD;
            idx_nxt   = 2'd0;
            guard_nxt = GW'(GUARD_CYCLES);
          end
        end
        GUARD: begin
          if (guard_cnt <= GW'(1)) begin
            state_nxt = LISTEN;
            guard_nxt = '0;
            dwell_nxt = dwell_load;
          end else begin
            guard_nxt = guard_cnt - GW'(1);
          end
        end
        LISTEN: begin
          // The match cycle still counts as a dwell clock; the remainder is frozen.
          dwell_nxt = (dwell_cnt == 16'd0) ? 16'd0 : dwell_cnt - 16'd1;
          if (acc_addr_matched) begin
            state_nxt = RECEIVE;
            rx_nxt    = RW'(RX_TIMEOUT);
          end else if (dwell_cnt <= 16'd1) begin
            state_nxt = GUARD;
            idx_nxt   = idx_adv;
            guard_nxt = GW'(GUARD_CYCLES);
          end
        end
        RECEIVE: begin
          if (packet_detected) begin
            cap       = 1'b1;
            state_nxt = GUARD;
            idx_nxt   = idx_adv;
            guard_nxt = GW'(GUARD_CYCLES);
            rx_nxt    = '0;
          end else if (rx_cnt <= RW'(1)) begin
            rx_nxt = '0;
            if (dwell_cnt == 16'd0) begin
              state_nxt = GUARD;
              idx_nxt   = idx_adv;
              guard_nxt = GW'(GUARD_CYCLES);
            end else begin
              state_nxt = LISTEN;
            end
          end else begin
            rx_nxt = rx_cnt - RW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Single-entry event buffer; a capture into a full, unread buffer is dropped.
  always_ff @(posedge symbol_clk or negedge rst) begin
    if (!rst) begin
      evt_valid   <= 1'b0;
      evt_channel <= 6'd0;
      evt_len     <= 9'd0;
      overflow    <= 1'b0;
    end else begin
      if (cap) begin
        if (!evt_valid || evt_ready) begin
          evt_valid   <= 1'b1;
          evt_channel <= sniff_channel;
          evt_len     <= packet_len;
        end else begin
          overflow <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (state == IDLE && start) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed bench for scan_scheduler: hop timing, capture, overflow, timeout resume,
// stop and reset behaviour, with hand-computed expectations.
module tb_scan_scheduler;
  logic        symbol_clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [17:0] ch_list;
  logic [1:0]  ch_count;
  logic [15:0] dwell;
  logic        sniff_en;
  logic [5:0]  sniff_channel;
  logic        acc_addr_matched = 1'b0;
  logic        packet_detected = 1'b0;
  logic [8:0]  packet_len = 9'd0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [5:0]  evt_channel;
  logic [8:0]  evt_len;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int n;

  scan_scheduler dut (
    .symbol_clk(symbol_clk), .rst(rst), .start(start), .stop(stop),
    .ch_list(ch_list), .ch_count(ch_count), .dwell(dwell),
    .sniff_en(sniff_en), .sniff_channel(sniff_channel),
    .acc_addr_matched(acc_addr_matched), .packet_detected(packet_detected),
    .packet_len(packet_len), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_channel(evt_channel), .evt_len(evt_len), .busy(busy), .overflow(overflow)
  );

  always #5 symbol_clk = ~symbol_clk;

  task automatic tick();
    @(posedge symbol_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts clocks while sniff_en stays at lvl, bounded so a stuck DUT still ends.
  task automatic run_while(input logic lvl, output int cnt);
    cnt = 0;
    while (sniff_en === lvl && cnt < 2000) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    ch_list  = {6'd39, 6'd38, 6'd37};
    ch_count = 2'd3;
    dwell    = 16'd100;
    #12;
    chk("rst_sniff_en", sniff_en, 0);
    chk("rst_channel", sniff_channel, 37);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_channel", evt_channel, 0);
    chk("rst_evt_len", evt_len, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // plain hopping, no traffic
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1);
    for (int d = 0; d < 4; d++) begin
      run_while(1'b0, n);
      chk("hop_guard_len", n, 8);
      chk("hop_channel", sniff_channel, 37 + (d % 3));
      run_while(1'b1, n);
      chk("hop_dwell_len", n, 100);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_sniff_en", sniff_en, 0);

    // match at dwell clock 40 on ch 38, packet 200 clocks later
    start = 1'b1; tick(); start = 1'b0;
    run_while(1'b0, n);
    run_while(1'b1, n);
    run_while(1'b0, n);
    chk("cap_listen_ch", sniff_channel, 38);
    repeat (39) tick();
    acc_addr_matched = 1'b1; tick(); acc_addr_matched = 1'b0;
    chk("rx_sniff_en", sniff_en, 1);
    repeat (199) tick();
    packet_detected = 1'b1; packet_len = 9'd296; tick(); packet_detected = 1'b0;
    chk("cap_evt_valid", evt_valid, 1);
    chk("cap_evt_channel", evt_channel, 38);
    chk("cap_evt_len", evt_len, 296);
    chk("cap_sniff_en", sniff_en, 0);
    run_while(1'b0, n);
    chk("cap_guard_len", n, 8);
    chk("cap_next_ch", sniff_channel, 39);

    // second capture with the buffer full and not read
    acc_addr_matched = 1'b1; tick(); acc_addr_matched = 1'b0;
    packet_detected = 1'b1; packet_len = 9'd100; tick(); packet_detected = 1'b0;
    chk("ovf_evt_valid", evt_valid, 1);
    chk("ovf_evt_channel", evt_channel, 38);
    chk("ovf_evt_len", evt_len, 296);
    chk("ovf_flag", overflow, 1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    chk("pop_evt_valid", evt_valid, 0);

    // receive timeout resumes the remaining 60 dwell clocks
    run_while(1'b0, n);
    chk("to_listen_ch", sniff_channel, 37);
    repeat (39) tick();
    acc_addr_matched = 1'b1; tick(); acc_addr_matched = 1'b0;
    run_while(1'b1, n);
    chk("to_high_len", n, 376 + 60);
    chk("to_no_event", evt_valid, 0);
    chk("to_next_ch", sniff_channel, 38);

    // stop beats a simultaneous packet_detected
    run_while(1'b0, n);
    acc_addr_matched = 1'b1; tick(); acc_addr_matched = 1'b0;
    packet_detected = 1'b1; stop = 1'b1; packet_len = 9'd55; tick();
    packet_detected = 1'b0; stop = 1'b0;
    chk("stopdet_busy", busy, 0);
    chk("stopdet_sniff_en", sniff_en, 0);
    tick();
    chk("stopdet_no_event", evt_valid, 0);

    // start clears overflow; capture coinciding with a pop reloads the buffer
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_ovf_clr", overflow, 0);
    run_while(1'b0, n);
    acc_addr_matched = 1'b1; tick(); acc_addr_matched = 1'b0;
    packet_detected = 1'b1; packet_len = 9'd10; tick(); packet_detected = 1'b0;
    chk("c1_evt_valid", evt_valid, 1);
    chk("c1_evt_channel", evt_channel, 37);
    run_while(1'b0, n);
    chk("c2_listen_ch", sniff_channel, 38);
    acc_addr_matched = 1'b1; tick(); acc_addr_matched = 1'b0;
    packet_detected = 1'b1; packet_len = 9'd20; evt_ready = 1'b1; tick();
    packet_detected = 1'b0; evt_ready = 1'b0;
    chk("c2_evt_valid", evt_valid, 1);
    chk("c2_evt_channel", evt_channel, 38);
    chk("c2_evt_len", evt_len, 20);
    chk("c2_overflow", overflow, 0);

    // pending event survives stop/start
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("keep_evt_valid", evt_valid, 1);
    chk("keep_evt_len", evt_len, 20);

    // live ch_list change, then reset mid-LISTEN
    run_while(1'b0, n);
    repeat (5) tick();
    ch_list[5:0] = 6'd45; #1;
    chk("live_ch_change", sniff_channel, 45);
    rst = 1'b0; #1;
    chk("mrst_sniff_en", sniff_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_evt_valid", evt_valid, 0);
    chk("mrst_evt_channel", evt_channel, 0);
    chk("mrst_evt_len", evt_len, 0);
    chk("mrst_channel", sniff_channel, 45);
    ch_list[5:0] = 6'd37;
    rst = 1'b1;
    tick();

    // ch_count=0 and dwell=0 degenerate to one channel, one-clock listen
    ch_count = 2'd0;
    dwell    = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      run_while(1'b0, n);
      chk("min_guard_len", n, 8);
      chk("min_channel", sniff_channel, 37);
      run_while(1'b1, n);
      chk("min_dwell_len", n, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
